// File: rtl/second_cnn_pkg.sv
// Shared definitions for the second conv layer's downstream stages:
// channel count, default sample width, signed sample types and the
// saturation limits of the 8-bit activation format.
package second_cnn_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CH        = 8;

    typedef logic signed [7:0]  s8_t;
    typedef logic signed [15:0] s16_t;

    localparam s8_t SAT_MAX8 = s8_t'(8'h7f);
    localparam s8_t SAT_MIN8 = s8_t'(8'h80);

endpackage

// File: rtl/second_pool_relu_pool_channel.sv
// pool_channel: one channel of the 2x2 stride-2 max pool.
// Holds the even-column sample, forms the horizontal pair maximum, parks
// even-row pair maxima in a line buffer of IMG_W/2 entries and, on the odd
// row, combines them into the window maximum, which is shifted and
// saturated into the output register.
// Optional ReLU: SECOND_POOL_RELU_EN clamps negative results to zero.
module pool_channel
    import second_cnn_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IMG_W = 8,
    parameter int SHIFT = 4,
    parameter int IDX_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_accept,
    input  logic                      i_col_odd,
    input  logic                      i_row_odd,
    input  logic [IDX_W-1:0]          i_idx,
    input  logic signed [2*WIDTH-1:0] i_din,
    output logic signed [WIDTH-1:0]   o_dout
);

    localparam int DW    = 2 * WIDTH;
    localparam int DEPTH = IMG_W / 2;

    // Output range limits expressed at the wide sample width.
    localparam logic signed [DW-1:0] SAT_HI = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_LO = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Arithmetic shift then clamp into the narrow signed range.
    // ReLU after max equals ReLU before max, so it lives only here.
    function automatic logic signed [WIDTH-1:0] requant(input logic signed [DW-1:0] p);
        logic signed [DW-1:0] s;
        s = p >>> SHIFT;
`ifdef SECOND_POOL_RELU_EN
        if (s < 0) begin
            s = '0;
        end
`endif
        if (s > SAT_HI) begin
            return signed'(SAT_HI[WIDTH-1:0]);
        end else if (s < SAT_LO) begin
            return signed'(SAT_LO[WIDTH-1:0]);
        end else begin
            return signed'(s[WIDTH-1:0]);
        end
    endfunction

    logic signed [DW-1:0]    r_h_p0;
    logic signed [DW-1:0]    r_line [DEPTH];
    logic signed [DW-1:0]    w_hm;
    logic signed [DW-1:0]    w_pool;
    logic signed [WIDTH-1:0] r_dout_p1;

    assign w_hm   = smax(r_h_p0, i_din);
    assign w_pool = smax(r_line[i_idx], w_hm);

    // Stage 0 -> 1: hold even-column sample, register requantised window maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_p0    <= '0;
            r_dout_p1 <= '0;
        end else if (i_accept) begin
            if (!i_col_odd) begin
                r_h_p0 <= i_din;
            end else if (i_row_odd) begin
                r_dout_p1 <= requant(w_pool);
            end
        end
    end

    // Line buffer: even-row pair maxima, written before the odd row reads them.
    always_ff @(posedge clk) begin
        if (i_accept && i_col_odd && !i_row_odd) begin
            r_line[i_idx] <= w_hm;
        end
    end

    assign o_dout = r_dout_p1;

endmodule

// File: rtl/second_pool_relu.sv
// second_pool_relu: 2x2 stride-2 max pooling of the second conv layer's
// 8 signed 2*WIDTH-bit channels, requantised back to WIDTH-bit signed.
// Tracks the raster position, restarts on Din_Sof, and flags each pooled
// pixel and the end of frame one cycle after the accepting edge.
// Optional ReLU: define SECOND_POOL_RELU_EN to clamp negative outputs to 0.
module second_pool_relu
    import second_cnn_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int SHIFT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Din_Valid,
    input  logic                      Din_Sof,
    input  logic signed [2*WIDTH-1:0] Din0,
    input  logic signed [2*WIDTH-1:0] Din1,
    input  logic signed [2*WIDTH-1:0] Din2,
    input  logic signed [2*WIDTH-1:0] Din3,
    input  logic signed [2*WIDTH-1:0] Din4,
    input  logic signed [2*WIDTH-1:0] Din5,
    input  logic signed [2*WIDTH-1:0] Din6,
    input  logic signed [2*WIDTH-1:0] Din7,
    output logic                      Dout_Valid,
    output logic signed [WIDTH-1:0]   Dout0,
    output logic signed [WIDTH-1:0]   Dout1,
    output logic signed [WIDTH-1:0]   Dout2,
    output logic signed [WIDTH-1:0]   Dout3,
    output logic signed [WIDTH-1:0]   Dout4,
    output logic signed [WIDTH-1:0]   Dout5,
    output logic signed [WIDTH-1:0]   Dout6,
    output logic signed [WIDTH-1:0]   Dout7,
    output logic                      Frame_Done
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int IDX_W = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic                      w_accept;
    logic                      w_sof;
    logic [CW-1:0]             w_col;
    logic [RW-1:0]             w_row;
    logic [IDX_W-1:0]          w_idx;
    logic [CW-1:0]             r_col;
    logic [RW-1:0]             r_row;
    logic                      r_vld_p1;
    logic                      r_done_p1;
    logic signed [2*WIDTH-1:0] w_din  [CH];
    logic signed [WIDTH-1:0]   w_dout [CH];

    assign w_accept = Din_Valid;
    assign w_sof    = Din_Valid & Din_Sof;

    // A start-of-frame pixel is placed at (0,0) regardless of the counters,
    // which drops any partial frame and realigns the pooling windows.
    assign w_col = w_sof ? '0 : r_col;
    assign w_row = w_sof ? '0 : r_row;
    assign w_idx = IDX_W'(w_col >> 1);

    assign w_din[0] = Din0;
    assign w_din[1] = Din1;
    assign w_din[2] = Din2;
    assign w_din[3] = Din3;
    assign w_din[4] = Din4;
    assign w_din[5] = Din5;
    assign w_din[6] = Din6;
    assign w_din[7] = Din7;

    // Raster position counters, advanced once per accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // Stage 0 -> 1: output strobe on each window's 4th pixel, end-of-frame on the last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_done_p1 <= 1'b0;
        end else begin
            r_vld_p1  <= w_accept && w_col[0] && w_row[0];
            r_done_p1 <= w_accept && (w_col == COL_LAST) && (w_row == ROW_LAST);
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        pool_channel #(
            .WIDTH (WIDTH),
            .IMG_W (IMG_W),
            .SHIFT (SHIFT),
            .IDX_W (IDX_W)
        ) u_pool (
            .clk       (clk),
            .rst       (rst),
            .i_accept  (w_accept),
            .i_col_odd (w_col[0]),
            .i_row_odd (w_row[0]),
            .i_idx     (w_idx),
            .i_din     (w_din[g]),
            .o_dout    (w_dout[g])
        );
    end

    assign Dout_Valid = r_vld_p1;
    assign Frame_Done = r_done_p1;
    assign Dout0      = w_dout[0];
    assign Dout1      = w_dout[1];
    assign Dout2      = w_dout[2];
    assign Dout3      = w_dout[3];
    assign Dout4      = w_dout[4];
    assign Dout5      = w_dout[5];
    assign Dout6      = w_dout[6];
    assign Dout7      = w_dout[7];

endmodule

// File: tb/tb_second_pool_relu.sv
// Bench for second_pool_relu at IMG_W=4, IMG_H=4, SHIFT=2, WIDTH=8.
// Directed frames with hand-computed pooled results; expectations follow
// the SECOND_POOL_RELU_EN build option.
module tb_second_pool_relu;

    localparam int W  = 8;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int SH = 2;

`ifdef SECOND_POOL_RELU_EN
    localparam logic signed [W-1:0] EXP_NEG_SAT = 8'sd0;
    localparam logic signed [W-1:0] EXP_NEG_WIN = 8'sd0;
`else
    localparam logic signed [W-1:0] EXP_NEG_SAT = -8'sd128;
    localparam logic signed [W-1:0] EXP_NEG_WIN = -8'sd1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    din_valid;
    logic                    din_sof;
    logic signed [2*W-1:0]   din  [8];
    logic                    dout_valid;
    logic                    frame_done;
    logic signed [W-1:0]     dout [8];

    int n_cmp = 0;
    int n_bad = 0;

    second_pool_relu #(
        .WIDTH (W),
        .IMG_W (IW),
        .IMG_H (IH),
        .SHIFT (SH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Din_Valid  (din_valid),
        .Din_Sof    (din_sof),
        .Din0       (din[0]),
        .Din1       (din[1]),
        .Din2       (din[2]),
        .Din3       (din[3]),
        .Din4       (din[4]),
        .Din5       (din[5]),
        .Din6       (din[6]),
        .Din7       (din[7]),
        .Dout_Valid (dout_valid),
        .Dout0      (dout[0]),
        .Dout1      (dout[1]),
        .Dout2      (dout[2]),
        .Dout3      (dout[3]),
        .Dout4      (dout[4]),
        .Dout5      (dout[5]),
        .Dout6      (dout[6]),
        .Dout7      (dout[7]),
        .Frame_Done (frame_done)
    );

    // One clock: inputs applied at the falling edge, outputs observed 1 ns after the rising edge.
    task automatic drive(input logic v, input logic sof);
        @(negedge clk);
        din_valid = v;
        din_sof   = sof;
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic signed [2*W-1:0] val);
        for (int c = 0; c < 8; c++) din[c] = val;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        din_sof = 1'b0;
        set_all('0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (dout_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %0b expected 0", dout_valid);
        end
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_bad++; $display("FAIL reset_done: got %0b expected 0", frame_done);
        end
        for (int c = 0; c < 8; c++) begin
            n_cmp++;
            if (dout[c] !== 8'sd0) begin
                n_bad++; $display("FAIL reset_dout%0d: got %0d expected 0", c, dout[c]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ch0 carries 0..15 in raster order, other channels 0; optional idle gap after each pixel.
    task automatic run_ramp(input string name, input int gap, input logic sof_first);
        logic signed [W-1:0] exp_seq [4];
        int outk;
        logic exp_v;
        exp_seq = '{8'sd1, 8'sd1, 8'sd3, 8'sd3};
        outk = 0;
        for (int i = 0; i < 16; i++) begin
            set_all('0);
            din[0] = 16'(i);
            drive(1'b1, sof_first && (i == 0));
            exp_v = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
            n_cmp++;
            if (dout_valid !== exp_v) begin
                n_bad++; $display("FAIL %s_valid px%0d: got %0b expected %0b", name, i, dout_valid, exp_v);
            end
            n_cmp++;
            if (frame_done !== 1'(i == 15)) begin
                n_bad++; $display("FAIL %s_done px%0d: got %0b expected %0b", name, i, frame_done, (i == 15));
            end
            if (exp_v) begin
                n_cmp++;
                if (dout[0] !== exp_seq[outk]) begin
                    n_bad++; $display("FAIL %s_dout0 out%0d: got %0d expected %0d", name, outk, dout[0], exp_seq[outk]);
                end
                n_cmp++;
                if (dout[1] !== 8'sd0) begin
                    n_bad++; $display("FAIL %s_dout1 out%0d: got %0d expected 0", name, outk, dout[1]);
                end
                outk++;
            end
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'b0);
                n_cmp++;
                if (dout_valid !== 1'b0 || frame_done !== 1'b0) begin
                    n_bad++; $display("FAIL %s_idle px%0d: got valid=%0b done=%0b expected 0/0", name, i, dout_valid, frame_done);
                end
                if (outk > 0) begin
                    n_cmp++;
                    if (dout[0] !== exp_seq[outk-1]) begin
                        n_bad++; $display("FAIL %s_hold px%0d: got %0d expected %0d", name, i, dout[0], exp_seq[outk-1]);
                    end
                end
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_ramp();
        run_ramp("ramp", 0, 1'b1);
    endtask

    task automatic run_const_frame(input string name, input logic signed [2*W-1:0] val,
                                   input logic signed [W-1:0] expv);
        for (int i = 0; i < 16; i++) begin
            set_all(val);
            drive(1'b1, i == 0);
            if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
                n_cmp++;
                if (dout_valid !== 1'b1) begin
                    n_bad++; $display("FAIL %s_valid px%0d: got %0b expected 1", name, i, dout_valid);
                end
                for (int c = 0; c < 8; c++) begin
                    n_cmp++;
                    if (dout[c] !== expv) begin
                        n_bad++; $display("FAIL %s_dout%0d px%0d: got %0d expected %0d", name, c, i, dout[c], expv);
                    end
                end
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_saturation();
        run_const_frame("sat_pos", 16'sd1000, 8'sd127);
        run_const_frame("sat_neg", -16'sd1000, EXP_NEG_SAT);
    endtask

    task automatic test_negative_window();
        logic signed [2*W-1:0] ch3 [16];
        for (int i = 0; i < 16; i++) ch3[i] = '0;
        ch3[0] = -16'sd8;
        ch3[1] = -16'sd4;
        ch3[4] = -16'sd12;
        ch3[5] = -16'sd16;
        for (int i = 0; i < 16; i++) begin
            set_all('0);
            din[3] = ch3[i];
            drive(1'b1, i == 0);
            if (i == 5) begin
                n_cmp++;
                if (dout_valid !== 1'b1 || dout[3] !== EXP_NEG_WIN) begin
                    n_bad++; $display("FAIL negwin_dout3: got valid=%0b val=%0d expected 1/%0d", dout_valid, dout[3], EXP_NEG_WIN);
                end
                n_cmp++;
                if (dout[2] !== 8'sd0) begin
                    n_bad++; $display("FAIL negwin_dout2: got %0d expected 0", dout[2]);
                end
            end
            if (i == 7) begin
                n_cmp++;
                if (dout[3] !== 8'sd0) begin
                    n_bad++; $display("FAIL negwin_next: got %0d expected 0", dout[3]);
                end
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_gapped();
        run_ramp("gap", 1, 1'b1);
    endtask

    // Partial frame of 6 large pixels, then a fresh Sof frame must pool as if from (0,0).
    task automatic test_sof_restart();
        for (int i = 0; i < 6; i++) begin
            set_all(16'sd100);
            drive(1'b1, i == 0);
        end
        run_ramp("sof", 0, 1'b1);
        drive(1'b0, 1'b0);
        n_cmp++;
        if (dout_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_bad++; $display("FAIL sof_after: got valid=%0b done=%0b expected 0/0", dout_valid, frame_done);
        end
    endtask

    task automatic test_back_to_back();
        run_ramp("b2b_a", 0, 1'b1);
        run_ramp("b2b_b", 0, 1'b0);
    endtask

    task automatic test_rst_midframe();
        for (int i = 0; i < 6; i++) begin
            set_all(16'sd1000);
            drive(1'b1, i == 0);
        end
        n_cmp++;
        if (dout_valid !== 1'b1 || dout[5] !== 8'sd127) begin
            n_bad++; $display("FAIL rstmid_pre: got valid=%0b val=%0d expected 1/127", dout_valid, dout[5]);
        end
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (dout_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_ctrl: got valid=%0b done=%0b expected 0/0", dout_valid, frame_done);
        end
        for (int c = 0; c < 8; c++) begin
            n_cmp++;
            if (dout[c] !== 8'sd0) begin
                n_bad++; $display("FAIL rstmid_dout%0d: got %0d expected 0", c, dout[c]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        run_ramp("rstmid", 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        din_valid = 1'b0;
        din_sof = 1'b0;
        for (int c = 0; c < 8; c++) din[c] = '0;
        test_reset();
        test_ramp();
        test_saturation();
        test_negative_window();
        test_gapped();
        test_sof_restart();
        test_back_to_back();
        test_rst_midframe();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
